// File: rtl/uart_tx.sv
// UART transmitter: takes one byte per valid/ready handshake and sends
// start, DATA_BITS data bits LSB first, optional parity and stop bit(s).
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       input_valid,
  output logic       input_ready,
  input  logic [7:0] data_in,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned       BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [7:0]        DATA_MASK = 8'((32'd1 << DATA_BITS) - 32'd1);
  localparam logic              ODD_SEL   = (PARITY_ODD != 0);
  localparam logic              HAS_PAR   = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t            state, state_nxt;
  logic [BAUD_W-1:0] baud_cnt, baud_nxt;
  logic [2:0]        bit_cnt, bit_nxt;
  logic [7:0]        shift, shift_nxt;
  logic              parity, parity_nxt;
  logic              tx_nxt;
  logic              baud_last;
  logic              accept;

  always_comb begin
    baud_last   = (baud_cnt == BAUD_LAST);
    input_ready = (state == IDLE) ||
                  ((state == STOP) && (bit_cnt == STOP_LAST) && baud_last);
    accept      = input_valid && input_ready;
  end

  always_comb begin
    state_nxt  = state;
    baud_nxt   = baud_last ? '0 : baud_cnt + BAUD_W'(1);
    bit_nxt    = bit_cnt;
    shift_nxt  = shift;
    parity_nxt = parity;
    tx_nxt     = 1'b1;

    case (state)
      IDLE: begin
        baud_nxt = '0;
        bit_nxt  = '0;
      end
      START: begin
        tx_nxt = 1'b0;
        if (baud_last) begin
          state_nxt = DATA;
          bit_nxt   = '0;
        end
      end
      DATA: begin
        tx_nxt = shift[0];
        if (baud_last) begin
          shift_nxt = {1'b0, shift[7:1]};
          if (bit_cnt == DATA_LAST) begin
            bit_nxt   = '0;
            state_nxt = HAS_PAR ? PARITY : STOP;
          end else begin
            bit_nxt = bit_cnt + 3'd1;
          end
        end
      end
      PARITY: begin
        tx_nxt = parity;
        if (baud_last) begin
          state_nxt = STOP;
          bit_nxt   = '0;
        end
      end
      STOP: begin
        tx_nxt = 1'b1;
        if (baud_last) begin
          if (bit_cnt == STOP_LAST) begin
            state_nxt = IDLE;
            bit_nxt   = '0;
          end else begin
            bit_nxt = bit_cnt + 3'd1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        baud_nxt  = '0;
        bit_nxt   = '0;
      end
    endcase

    // Loading is shared by IDLE and the final stop cycle so frames chain gaplessly.
    if (accept) begin
      state_nxt  = START;
      baud_nxt   = '0;
      bit_nxt    = '0;
      shift_nxt  = data_in;
      parity_nxt = (^(data_in & DATA_MASK)) ^ ODD_SEL;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      parity   <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      shift    <= shift_nxt;
      parity   <= parity_nxt;
      tx       <= tx_nxt;
      busy     <= (state != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: three instances (8N1, 8E2, 8O2) at 4 clocks per bit,
// expected frames built from the framing rules and checked by per-line monitors.
module tb_uart_tx;

  localparam int unsigned C = 4;

  typedef struct {
    int          inst;
    logic [11:0] bits;
    int          len;
    int          acc;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] valid = '0;
  logic [2:0] ready;
  logic [2:0] txl;
  logic [2:0] busy;
  logic [7:0] din [3];

  int     cyc = 0;
  int     checks = 0;
  int     passes = 0;
  frame_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx #(.CLKS_PER_BIT(C)) u_8n1 (
    .clk(clk), .reset(rst_n), .input_valid(valid[0]), .input_ready(ready[0]),
    .data_in(din[0]), .tx(txl[0]), .busy(busy[0]));

  uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_8e2 (
    .clk(clk), .reset(rst_n), .input_valid(valid[1]), .input_ready(ready[1]),
    .data_in(din[1]), .tx(txl[1]), .busy(busy[1]));

  uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_8o2 (
    .clk(clk), .reset(rst_n), .input_valid(valid[2]), .input_ready(ready[2]),
    .data_in(din[2]), .tx(txl[2]), .busy(busy[2]));

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
  endtask

  // Reference frame: line levels in transmit order, derived from the framing rules.
  function automatic frame_t model(input int i, input logic [7:0] b, input int acc);
    frame_t f;
    int     n, ones;
    f.inst = i;
    f.acc  = acc;
    f.bits = '0;
    n      = 1;
    ones   = 0;
    for (int k = 0; k < 8; k++) begin
      f.bits[n] = b[k];
      ones      = ones + int'(b[k]);
      n         = n + 1;
    end
    if (i != 0) begin
      f.bits[n] = ((ones % 2) == 1) ^ (i == 2);
      n         = n + 1;
    end
    for (int s = 0; s < ((i == 0) ? 1 : 2); s++) begin
      f.bits[n] = 1'b1;
      n         = n + 1;
    end
    f.len = n;
    return f;
  endfunction

  // Handshake observer: inputs are stable at the falling edge before the accepting edge.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 3; i++)
        if (valid[i] && ready[i]) sb.push_back(model(i, din[i], cyc + 1));
    end
  end

  task automatic monitor(input int i);
    frame_t      f;
    int          len, start_cyc;
    logic [11:0] got;
    bit          uniform, aborted;
    forever begin
      @(negedge clk);
      if (rst_n && txl[i] == 1'b0) begin
        len       = (i == 0) ? 10 : 12;
        start_cyc = cyc;
        got       = '0;
        uniform   = 1'b1;
        aborted   = 1'b0;
        for (int k = 0; k < len * int'(C); k++) begin
          if (k != 0) @(negedge clk);
          if (!rst_n) begin
            aborted = 1'b1;
            break;
          end
          if (k % int'(C) == 0) got[k / int'(C)] = txl[i];
          else if (txl[i] !== got[k / int'(C)]) uniform = 1'b0;
        end
        if (!aborted) begin
          check(sb.size() != 0, $sformatf("unexpected_frame_line%0d", i), sb.size(), 1);
          if (sb.size() != 0) begin
            f = sb.pop_front();
            check(f.inst == i, "frame_line", i, f.inst);
            check(uniform, $sformatf("bit_hold_line%0d", i), uniform, 1);
            check(got == f.bits, $sformatf("frame_bits_line%0d", i), got, f.bits);
            check(start_cyc == f.acc + 1, $sformatf("start_latency_line%0d", i),
                  start_cyc - f.acc, 1);
          end
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);
  initial monitor(2);

  // Caller is just after a rising edge; returns just after the accepting edge.
  task automatic send(input int i, input logic [7:0] b);
    int t = 0;
    valid[i] = 1'b1;
    din[i]   = b;
    @(negedge clk);
    while (!ready[i] && t < 200) begin
      @(negedge clk);
      t++;
    end
    check(ready[i], "send_accept", ready[i], 1);
    @(posedge clk);
    #1;
    valid[i] = 1'b0;
    din[i]   = 8'($urandom);
  endtask

  task automatic feed_byte(input int i, input logic [7:0] b);
    bit done = 1'b0;
    int t    = 0;
    while (!done && t < 400) begin
      valid[i] = 1'($urandom_range(0, 1));
      din[i]   = valid[i] ? b : 8'($urandom);
      @(negedge clk);
      done = valid[i] && ready[i];
      @(posedge clk);
      #1;
      t++;
    end
    valid[i] = 1'b0;
    check(done, "feed_accept", done, 1);
  endtask

  task automatic drain();
    int t = 0;
    @(negedge clk);
    while ((sb.size() != 0 || busy != '0) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check(sb.size() == 0 && busy == '0, "drain", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic count_busy(input int i, input int n, output int busy_hi, output int rdy_lo);
    busy_hi = 0;
    rdy_lo  = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (busy[i]) busy_hi++;
      if (!ready[i]) rdy_lo++;
    end
  endtask

  initial begin
    int          bh, rl;
    int          acc [3];
    logic [7:0]  b2b [3];
    logic [31:0] word;
    for (int i = 0; i < 3; i++) din[i] = 8'($urandom);

    // Reset asserted mid-cycle.
    #3 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check(txl[i] == 1'b1, $sformatf("reset_tx_line%0d", i), txl[i], 1);
      check(busy[i] == 1'b0, $sformatf("reset_busy_line%0d", i), busy[i], 0);
      check(ready[i] == 1'b1, $sformatf("reset_ready_line%0d", i), ready[i], 1);
    end
    repeat (2) @(posedge clk);
    #1;
    check(txl[0] == 1'b1, "reset_held_tx", txl[0], 1);
    check(busy[0] == 1'b0, "reset_held_busy", busy[0], 0);
    check(ready[0] == 1'b1, "reset_held_ready", ready[0], 1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single byte 8N1.
    send(0, 8'hA5);
    count_busy(0, 48, bh, rl);
    check(bh == 40, "8n1_busy_cycles", bh, 40);
    check(rl == 39, "8n1_ready_low_cycles", rl, 39);
    drain();

    // 8E2 and 8O2 with 0x07.
    send(1, 8'h07);
    count_busy(1, 56, bh, rl);
    check(bh == 48, "8e2_busy_cycles", bh, 48);
    drain();
    send(2, 8'h07);
    count_busy(2, 56, bh, rl);
    check(bh == 48, "8o2_busy_cycles", bh, 48);
    drain();

    // Back-to-back with valid held high.
    b2b[0] = 8'h55;
    b2b[1] = 8'hAA;
    b2b[2] = 8'h00;
    valid[0] = 1'b1;
    din[0]   = b2b[0];
    for (int j = 0; j < 3; j++) begin
      int t = 0;
      @(negedge clk);
      while (!ready[0] && t < 200) begin
        @(negedge clk);
        t++;
      end
      acc[j] = cyc + 1;
      @(posedge clk);
      #1;
      if (j < 2) din[0] = b2b[j + 1];
      else valid[0] = 1'b0;
    end
    check(acc[1] - acc[0] == 40, "b2b_accept_2", acc[1] - acc[0], 40);
    check(acc[2] - acc[0] == 80, "b2b_accept_3", acc[2] - acc[0], 80);
    count_busy(0, 40, bh, rl);
    check(bh == 40, "b2b_busy_held", bh, 40);
    drain();

    // Upstream 32->8 stage emitting the word low byte first, with bursty valid.
    word = 32'hDEADBEEF;
    for (int k = 0; k < 4; k++) begin
      logic [31:0] w;
      w = word >> (8 * k);
      feed_byte(0, w[7:0]);
    end
    drain();

    // Random bytes on every line configuration.
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 3; k++) feed_byte(i, 8'($urandom));
      drain();
    end

    // Reset during data bit 3 of 0xFF, then a clean 0x3C frame.
    send(0, 8'hFF);
    repeat (18) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check(txl[0] == 1'b1, "midreset_tx", txl[0], 1);
    check(busy[0] == 1'b0, "midreset_busy", busy[0], 0);
    check(ready[0] == 1'b1, "midreset_ready", ready[0], 1);
    sb.delete();
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    check(busy[0] == 1'b0 && txl[0] == 1'b1, "post_reset_idle", {busy[0], txl[0]}, 1);
    send(0, 8'h3C);
    drain();

    check(sb.size() == 0, "leftover_frames", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
